// File: rtl/isqrt_pkg.sv
// ============================================================================
// isqrt_pkg : shared state encoding and width helpers for the isqrt engine
// Rev 1.0
// ============================================================================
`default_nettype none

package isqrt_pkg;

    // ROUND keeps its code point even in builds that never enter it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int root_width(input int width);
        return width / 2;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_step.sv
// ============================================================================
// isqrt_step : one combinational restoring square-root iteration
// Rev 1.0
// ============================================================================
`default_nettype none

module isqrt_step #(
    parameter int R = 8
) (
    input  logic [R+1:0] rem_in,
    input  logic [R-1:0] q_in,
    input  logic [1:0]   x_top,
    output logic [R+1:0] rem_out,
    output logic         root_bit
);

    logic [R+1:0] shifted;
    logic [R+1:0] trial;
    logic         unused_hi;

    // The partial remainder never exceeds 2q, so its two top bits are
    // always zero when shifted and can be dropped.
    assign unused_hi = ^rem_in[R+1:R];

    always_comb begin
        shifted  = {rem_in[R-1:0], x_top};
        trial    = {q_in, 2'b01};
        root_bit = (shifted >= trial);
        rem_out  = root_bit ? (shifted - trial) : shifted;
    end

endmodule

`default_nettype wire

// File: rtl/isqrt_unit.sv
// ============================================================================
// isqrt_unit : multi-cycle Start/Ack integer square root, one root bit/clock
// Rev 1.0  -- define ISQRT_ROUND_EN for round-to-nearest root
// ============================================================================
`default_nettype none

module isqrt_unit
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    output logic [WIDTH/2-1:0] root,
    output logic [WIDTH/2:0]   remainder,
    output logic               busy,
    output logic               ack
);

    localparam int R  = root_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(R - 1);

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] x;
    logic [R+1:0]    rem;
    logic [R-1:0]    q;
    logic [CW-1:0]   cnt;

    logic            accept;
    logic            step_en;
    logic            last;
    logic [R+1:0]    rem_nxt;
    logic            root_bit;
    logic [R-1:0]    q_nxt;

    isqrt_step #(
        .R(R)
    ) u_step (
        .rem_in  (rem),
        .q_in    (q),
        .x_top   (x[WIDTH-1:WIDTH-2]),
        .rem_out (rem_nxt),
        .root_bit(root_bit)
    );

    assign q_nxt = {q[R-2:0], root_bit};
    assign last  = step_en && (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step_en   = 1'b0;
        busy      = 1'b0;
        ack       = 1'b0;
        case (state)
            IDLE, DONE: begin
                ack = (state == DONE);
                if (start) begin
                    state_nxt = CALC;
                    accept    = 1'b1;
                end
            end
            CALC: begin
                busy    = 1'b1;
                step_en = 1'b1;
                if (cnt == LAST_CNT) begin
`ifdef ISQRT_ROUND_EN
                    state_nxt = ROUND;
`else
                    state_nxt = DONE;
`endif
                end
            end
            ROUND: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ISQRT_ROUND_EN
    logic [R-1:0] rounded;

    // Remainder > q is exactly operand >= (q + 0.5)^2; an all-ones q saturates.
    assign rounded = (({2'b00, q} < rem) && (q != '1)) ? (q + 1'b1) : q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            rem       <= '0;
            q         <= '0;
            cnt       <= '0;
            root      <= '0;
            remainder <= '0;
        end else begin
            if (accept) begin
                x   <= operand;
                rem <= '0;
                q   <= '0;
                cnt <= '0;
            end else if (step_en) begin
                x   <= {x[WIDTH-3:0], 2'b00};
                rem <= rem_nxt;
                q   <= q_nxt;
                cnt <= cnt + 1'b1;
            end
`ifdef ISQRT_ROUND_EN
            if (state == ROUND) begin
                root      <= rounded;
                remainder <= rem[R:0];
            end
`else
            if (last) begin
                root      <= q_nxt;
                remainder <= rem_nxt[R:0];
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_isqrt_unit.sv
// ============================================================================
// tb_isqrt_unit : scoreboard bench for isqrt_unit (WIDTH=16), either build
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_isqrt_unit;

`ifdef ISQRT_ROUND_EN
    localparam int  LAT   = 9;
    localparam bit  ROUND = 1'b1;
`else
    localparam int  LAT   = 8;
    localparam bit  ROUND = 1'b0;
`endif

    typedef struct {
        logic [15:0] op;
        logic [7:0]  rf;
        logic [7:0]  rr;
        logic [8:0]  rm;
    } vec_t;

    typedef struct {
        logic [7:0] root;
        logic [8:0] rem;
        int         acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] operand = '0;
    logic [7:0]  root;
    logic [8:0]  remainder;
    logic        busy;
    logic        ack;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic ack_q = 1'b0;
    exp_t sb[$];

    isqrt_unit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .operand  (operand),
        .root     (root),
        .remainder(remainder),
        .busy     (busy),
        .ack      (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: each rising Ack retires the oldest expected result.
    always @(negedge clk) begin
        if (ack && !ack_q) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("root", root, e.root);
                chk("remainder", remainder, e.rem);
                chk("latency", cyc - e.acc, LAT);
            end
        end
        ack_q <= ack;
    end

    function automatic logic [7:0] pick(input vec_t v);
        return ROUND ? v.rr : v.rf;
    endfunction

    task automatic issue(input logic [15:0] op, input logic [7:0] er, input logic [8:0] em);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        operand = op;
        e.root  = er;
        e.rem   = em;
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ack) chk("ack_timeout", 0, 1);
    endtask

    vec_t vecs[12];

    initial begin
        // op, floor root, rounded root, remainder
        vecs[0]  = '{16'd190,   8'd13,  8'd14,  9'd21};
        vecs[1]  = '{16'd0,     8'd0,   8'd0,   9'd0};
        vecs[2]  = '{16'd16,    8'd4,   8'd4,   9'd0};
        vecs[3]  = '{16'd65535, 8'd255, 8'd255, 9'd510};
        vecs[4]  = '{16'd1,     8'd1,   8'd1,   9'd0};
        vecs[5]  = '{16'd2,     8'd1,   8'd1,   9'd1};
        vecs[6]  = '{16'd3,     8'd1,   8'd2,   9'd2};
        vecs[7]  = '{16'd255,   8'd15,  8'd16,  9'd30};
        vecs[8]  = '{16'd200,   8'd14,  8'd14,  9'd4};
        vecs[9]  = '{16'd65280, 8'd255, 8'd255, 9'd255};
        vecs[10] = '{16'd48399, 8'd219, 8'd220, 9'd438};
        vecs[11] = '{16'd10000, 8'd100, 8'd100, 9'd0};

        repeat (3) @(negedge clk);
        chk("rst_root", root, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].op, pick(vecs[i]), vecs[i].rm);
            wait_ack();
        end

        // Asynchronous reset three iterations into a calculation.
        @(negedge clk);
        start   = 1'b1;
        operand = 16'd190;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_root", root, 0);
        chk("midreset_remainder", remainder, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'd144, 8'd12, 9'd0);
        wait_ack();

        // Start pulsed mid-calculation with another operand is ignored.
        issue(16'd190, ROUND ? 8'd14 : 8'd13, 9'd21);
        @(negedge clk);
        start   = 1'b1;
        operand = 16'd65535;
        @(negedge clk);
        start   = 1'b0;
        operand = '0;
        wait_ack();

        // Start held high: back-to-back operations, one Ack cycle each.
        @(negedge clk);
        start   = 1'b1;
        operand = 16'd10000;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.root = 8'd100;
            e.rem  = 9'd0;
            e.acc  = cyc + 1 + i * (LAT + 1);
            sb.push_back(e);
        end
        begin
            int n = 0;
            int guard = 0;
            while (n < 3 && guard < 100) begin
                @(negedge clk);
                guard++;
                if (ack) n++;
            end
            start = 1'b0;
            chk("held_start_acks", n, 3);
        end

        repeat (LAT + 4) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("idle_after_hold", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
